// File: rtl/event_arb_pkg.sv
// event_arb_pkg: shared types and helpers for the BUF-stream arbiter.
//   arb_state_t        - arbiter FSM state (ARB = no grant, XFER = packet in flight)
//   DEF_BUF_*_WIDTH    - default stream widths
//   rr_next(ptr, n)    - wrap-increment of a round-robin pointer in 0..n-1
package event_arb_pkg;

  localparam int DEF_BUF_DATA_WIDTH = 512;
  localparam int DEF_BUF_KEEP_WIDTH = DEF_BUF_DATA_WIDTH / 8;

  typedef enum logic {ARB, XFER} arb_state_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_in);
    return (ptr + 32'd1 >= num_in) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/event_buf_arbiter_rr_pick.sv
// rr_pick: combinational circular priority encoder.
//   req_i   [N]   request vector
//   start_i [IW]  index with highest priority; priority falls off circularly
//   idx_o   [IW]  first set request at or after start_i
//   found_o       any request set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    // rotate so start_i lands on bit 0, then pick the lowest set bit
    rot     = N'({req_i, req_i} >> start_i);
    off     = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off     = IW'(k);
        found_o = 1'b1;
      end
    end
    // map offset back to an absolute index, modulo N
    sum   = (IW+1)'(start_i) + (IW+1)'(off);
    idx_o = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end

endmodule

// File: rtl/event_buf_arbiter.sv
// event_buf_arbiter: packet-granular round-robin merge of NUM_IN BUF
// AXI-stream inputs onto one registered BUF output. A grant is held from the
// first beat to the tlast beat so packets never interleave.
//   clk, rst                   clock, synchronous active-low reset
//   s_inbuf_axis_*             NUM_IN packed input streams (input i at slice i)
//   m_outbuf_axis_*            merged, registered output stream
//   m_grant_id                 source index of the beat on m_outbuf
//   m_pkt_count                (EVENT_ARB_STATS_EN only) 32-bit tlast counter per input
// Optional feature macro: EVENT_ARB_STATS_EN.
module event_buf_arbiter
  import event_arb_pkg::*;
#(
  parameter int NUM_IN         = 4,
  parameter int BUF_DATA_WIDTH = DEF_BUF_DATA_WIDTH,
  parameter int BUF_KEEP_WIDTH = DEF_BUF_KEEP_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_IN*BUF_DATA_WIDTH-1:0]   s_inbuf_axis_tdata,
  input  logic [NUM_IN*BUF_KEEP_WIDTH-1:0]   s_inbuf_axis_tkeep,
  input  logic [NUM_IN-1:0]                  s_inbuf_axis_tlast,
  input  logic [NUM_IN-1:0]                  s_inbuf_axis_tvalid,
  output logic [NUM_IN-1:0]                  s_inbuf_axis_tready,
  output logic [BUF_DATA_WIDTH-1:0]          m_outbuf_axis_tdata,
  output logic [BUF_KEEP_WIDTH-1:0]          m_outbuf_axis_tkeep,
  output logic                               m_outbuf_axis_tlast,
  output logic                               m_outbuf_axis_tvalid,
  input  logic                               m_outbuf_axis_tready,
  output logic [$clog2(NUM_IN)-1:0]          m_grant_id
`ifdef EVENT_ARB_STATS_EN
  ,output logic [NUM_IN*32-1:0]              m_pkt_count
`endif
);

  localparam int IW = $clog2(NUM_IN);

  arb_state_t                state_q;
  logic [IW-1:0]             grant_q, rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]             pick_idx;
  logic                      pick_found;

  logic                      out_vld_q, out_last_q;
  logic [BUF_DATA_WIDTH-1:0] out_data_q;
  logic [BUF_KEEP_WIDTH-1:0] out_keep_q;
  logic [IW-1:0]             out_id_q;

  logic [BUF_DATA_WIDTH-1:0] sel_data;
  logic [BUF_KEEP_WIDTH-1:0] sel_keep;
  logic                      sel_last, sel_valid;
  logic                      out_ready, accept;

  rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
    .req_i   (s_inbuf_axis_tvalid),
    .start_i (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // mux the granted input's beat
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q == IW'(i)) begin
        sel_data  = s_inbuf_axis_tdata[i*BUF_DATA_WIDTH +: BUF_DATA_WIDTH];
        sel_keep  = s_inbuf_axis_tkeep[i*BUF_KEEP_WIDTH +: BUF_KEEP_WIDTH];
        sel_last  = s_inbuf_axis_tlast[i];
        sel_valid = s_inbuf_axis_tvalid[i];
      end
    end
  end

  // output register can take a beat when empty or draining this cycle
  assign out_ready = !out_vld_q || m_outbuf_axis_tready;
  assign accept    = (state_q == XFER) && sel_valid && out_ready;
  assign rr_ptr_d  = IW'(rr_next(32'(grant_q), NUM_IN));

  always_comb begin
    s_inbuf_axis_tready = '0;
    if (state_q == XFER) s_inbuf_axis_tready[grant_q] = out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_id_q   <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept && sel_last) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ARB;
          end
        end
      endcase

      if (accept) begin
        out_vld_q  <= 1'b1;
        out_data_q <= sel_data;
        out_keep_q <= sel_keep;
        out_last_q <= sel_last;
        out_id_q   <= grant_q;
      end else if (m_outbuf_axis_tready) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign m_outbuf_axis_tvalid = out_vld_q;
  assign m_outbuf_axis_tdata  = out_data_q;
  assign m_outbuf_axis_tkeep  = out_keep_q;
  assign m_outbuf_axis_tlast  = out_last_q;
  assign m_grant_id           = out_id_q;

`ifdef EVENT_ARB_STATS_EN
  logic [NUM_IN-1:0][31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else if (accept && sel_last) cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
  end

  assign m_pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_event_buf_arbiter.sv
module tb_event_buf_arbiter;

  localparam int NI = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct packed {
    beat_t      b;
    logic [1:0] id;
  } obeat_t;

  logic              clk, rst;
  logic [NI*DW-1:0]  s_tdata;
  logic [NI*KW-1:0]  s_tkeep;
  logic [NI-1:0]     s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast, m_tvalid, m_tready;
  logic [1:0]        m_grant_id;
`ifdef EVENT_ARB_STATS_EN
  logic [NI*32-1:0]  pkt_cnt;
`endif

  event_buf_arbiter #(.NUM_IN(NI), .BUF_DATA_WIDTH(DW), .BUF_KEEP_WIDTH(KW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_inbuf_axis_tdata   (s_tdata),
    .s_inbuf_axis_tkeep   (s_tkeep),
    .s_inbuf_axis_tlast   (s_tlast),
    .s_inbuf_axis_tvalid  (s_tvalid),
    .s_inbuf_axis_tready  (s_tready),
    .m_outbuf_axis_tdata  (m_tdata),
    .m_outbuf_axis_tkeep  (m_tkeep),
    .m_outbuf_axis_tlast  (m_tlast),
    .m_outbuf_axis_tvalid (m_tvalid),
    .m_outbuf_axis_tready (m_tready),
    .m_grant_id           (m_grant_id)
`ifdef EVENT_ARB_STATS_EN
    ,.m_pkt_count         (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stimulus / reference state
  beat_t  srcq[NI][$];
  int     plen[NI][$];
  obeat_t expq[$];
  int     npk[NI];
  int     fixlen;     // 0 = random packet length 1..4
  int     rdy_mode;   // 0 = always ready, 1 = random, 2 = 1,0,0,1 pattern
  int     m_ptr;      // model round-robin pointer
  int     hs_cnt;

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    go(); go();
    rst = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < NI; i++) begin srcq[i].delete(); plen[i].delete(); end
    expq.delete();
  endtask

  task automatic run_round();
    int idx[NI];
    int left[NI];
    int len, j, cyc;
    logic [NI-1:0] fire, first_b;
    logic stall_prev, busy;
    logic [DW-1:0] prev_d;
    beat_t  bt;
    obeat_t ob;

    // generate packets
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < npk[i]; p++) begin
        len = (fixlen != 0) ? fixlen : int'($urandom_range(1, 4));
        plen[i].push_back(len);
        for (int b = 0; b < len; b++) begin
          bt.d = {$urandom, $urandom};
          bt.k = KW'($urandom);
          bt.l = (b == len - 1);
          srcq[i].push_back(bt);
        end
      end
      idx[i] = 0;
      left[i] = npk[i];
    end

    // reference: whole packets, next owner = first pending source at or after pointer
    while (1) begin
      j = -1;
      for (int s = 0; s < NI; s++) begin
        int c;
        c = (m_ptr + s) % NI;
        if (j < 0 && left[c] > 0) j = c;
      end
      if (j < 0) break;
      len = plen[j].pop_front();
      for (int b = 0; b < len; b++) begin
        ob.b  = srcq[j][idx[j]];
        ob.id = 2'(j);
        expq.push_back(ob);
        idx[j]++;
      end
      left[j]--;
      m_ptr = (j + 1) % NI;
    end

    first_b = '1; stall_prev = 1'b0; prev_d = '0; hs_cnt = 0; cyc = 0; busy = 1'b1;
    while (busy && cyc < 4000) begin
      for (int i = 0; i < NI; i++) begin
        if (srcq[i].size() > 0) begin
          s_tdata[i*DW +: DW] = srcq[i][0].d;
          s_tkeep[i*KW +: KW] = srcq[i][0].k;
          s_tlast[i]          = srcq[i][0].l;
          // first beats always offered; later beats may gap
          s_tvalid[i] = first_b[i] || (rdy_mode != 1) || ($urandom_range(0, 3) != 0);
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 2) != 0);
        default: m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase

      @(negedge clk);
      chk("rdy_onehot", 64'($countones(s_tready) <= 1), 64'd1);
      fire = s_tvalid & s_tready;
      if (stall_prev) begin
        chk("stall_vld", 64'(m_tvalid), 64'd1);
        chk("stall_data", m_tdata, prev_d);
      end
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        if (expq.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          ob = expq.pop_front();
          chk("out_data", m_tdata, ob.b.d);
          chk("out_meta", 64'({m_grant_id, m_tlast, m_tkeep}), 64'({ob.id, ob.b.l, ob.b.k}));
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_d = m_tdata;

      go();
      for (int i = 0; i < NI; i++) begin
        if (fire[i]) begin
          bt = srcq[i].pop_front();
          first_b[i] = bt.l;
        end
      end
      busy = (expq.size() > 0);
      for (int i = 0; i < NI; i++) busy = busy || (srcq[i].size() > 0);
      cyc++;
    end
    chk("round_drain", 64'(expq.size()), 64'd0);
    s_tvalid = '0;
    m_tready = 1'b1;
    go(); go();
  endtask

  initial begin
    rst = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b1;
    do_reset();

    // reset state, then idle
    @(negedge clk);
    chk("rst_vld", 64'(m_tvalid), 64'd0);
    chk("rst_rdy", 64'(s_tready), 64'd0);
    chk("rst_id", 64'(m_grant_id), 64'd0);
    repeat (20) go();
    @(negedge clk);
    chk("idle_vld", 64'(m_tvalid), 64'd0);
    chk("idle_rdy", 64'(s_tready), 64'd0);
    chk("idle_id", 64'(m_grant_id), 64'd0);

    // latency: single-beat packet on input 2
    go();
    s_tdata[2*DW +: DW] = 64'hA5A5_0000_1234_5678;
    s_tkeep[2*KW +: KW] = 8'h0F;
    s_tlast = 4'b0100;
    s_tvalid = 4'b0100;
    @(negedge clk);
    chk("lat_n_rdy", 64'(s_tready), 64'd0);
    go();
    @(negedge clk);
    chk("lat_n1_rdy", 64'(s_tready), 64'b0100);
    chk("lat_n1_vld", 64'(m_tvalid), 64'd0);
    go();
    s_tvalid = '0;
    @(negedge clk);
    chk("lat_n2_vld", 64'(m_tvalid), 64'd1);
    chk("lat_data", m_tdata, 64'hA5A5_0000_1234_5678);
    chk("lat_meta", 64'({m_grant_id, m_tlast, m_tkeep}), 64'({2'd2, 1'b1, 8'h0F}));
    go();
    @(negedge clk);
    chk("lat_drop", 64'(m_tvalid), 64'd0);

    // reset mid-packet: input 3 (pointer now at 3), reset at beat 2 of 4
    go();
    s_tdata[3*DW +: DW] = 64'h3000; s_tlast = 4'b0000; s_tvalid = 4'b1000;
    go();                                   // granted, beat 0 offered
    go(); s_tdata[3*DW +: DW] = 64'h3001;   // beat 0 accepted
    go(); s_tdata[3*DW +: DW] = 64'h3002;   // beat 1 accepted
    rst = 1'b0;
    s_tdata[0 +: DW] = 64'h0AAA; s_tlast[0] = 1'b1; s_tvalid = 4'b1001;
    go();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_vld", 64'(m_tvalid), 64'd0);
    chk("mrst_rdy", 64'(s_tready), 64'd0);
    chk("mrst_id", 64'(m_grant_id), 64'd0);
    go();
    @(negedge clk);
    chk("mrst_pick0", 64'(s_tready), 64'b0001);
    do_reset();

    // fairness: every input continuously offering 2-beat packets
    npk = '{3, 3, 3, 3}; fixlen = 2; rdy_mode = 0;
    run_round();

    // backpressure: one 4-beat packet from input 1 under a 1,0,0,1 ready pattern
    npk = '{0, 1, 0, 0}; fixlen = 4; rdy_mode = 2;
    run_round();
    chk("bp_hs", 64'(hs_cnt), 64'd4);

    // random traffic, valid gaps and backpressure
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) npk[i] = int'($urandom_range(0, 4));
      fixlen = 0; rdy_mode = 1;
      run_round();
    end

`ifdef EVENT_ARB_STATS_EN
    do_reset();
    npk = '{0, 3, 1, 0}; fixlen = 0; rdy_mode = 1;
    run_round();
    for (int i = 0; i < NI; i++)
      chk("pkt_count", 64'(pkt_cnt[i*32 +: 32]), 64'(npk[i]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/event_buf_arbiter.md
# event_buf_arbiter

Packet-granular round-robin arbiter that merges NUM_IN BUF AXI-stream outputs from event handler pipelines onto one BUF stream feeding the next event queue or the NET_SEND path. A grant is held from the first beat until the tlast beat, so packets never interleave. The output is registered, and each merged beat carries the ID of the source input.

## Interface
- NUM_IN, 4, number of requesting BUF streams; legal range 2..16
- BUF_DATA_WIDTH, 512, tdata width per stream
- BUF_KEEP_WIDTH, 64, tkeep width per stream; equals BUF_DATA_WIDTH/8
- clk  input  1  sole clock
- rst  input  1  synchronous, active-low reset
- s_inbuf_axis_tdata  input  NUM_IN*BUF_DATA_WIDTH  input i occupies slice [i*BUF_DATA_WIDTH +: BUF_DATA_WIDTH]
- s_inbuf_axis_tkeep  input  NUM_IN*BUF_KEEP_WIDTH  per-input keep, sliced the same way
- s_inbuf_axis_tlast  input  NUM_IN  per-input last
- s_inbuf_axis_tvalid  input  NUM_IN  per-input valid
- s_inbuf_axis_tready  output  NUM_IN  per-input ready; at most one bit high
- m_outbuf_axis_tdata  output  BUF_DATA_WIDTH  merged data
- m_outbuf_axis_tkeep  output  BUF_KEEP_WIDTH  merged keep
- m_outbuf_axis_tlast  output  1  merged last
- m_outbuf_axis_tvalid  output  1  merged valid
- m_outbuf_axis_tready  input  1  downstream ready
- m_grant_id  output  $clog2(NUM_IN)  source index of the beat on m_outbuf; only meaningful while tvalid is high

## Operation
- FSM states:
  - ARB: no grant held; all s_inbuf_axis_tready are 0.
    - Scan tvalid circularly, starting at rr_ptr.
    - The first set bit becomes grant_q. Move to XFER on the next edge.
    - If no bit is set, stay in ARB.
  - XFER: s_inbuf_axis_tready[grant_q] = out_ready; all other ready bits are 0.
    - out_ready = !m_outbuf_axis_tvalid || m_outbuf_axis_tready.
    - Each accepted beat (tvalid & tready on grant_q) is copied into the output register, along with grant_q into m_grant_id.
    - Accepting a beat with tlast=1 sets rr_ptr = grant_q+1, wrapping NUM_IN-1 to 0, and moves the FSM to ARB.
- The output register drops m_outbuf_axis_tvalid after a downstream handshake unless a new beat is loaded in the same cycle.
- Data, keep and last pass through unmodified. No width conversion.
- A single-beat packet (tlast on its first beat) is legal: ARB, then one XFER cycle, then ARB.
- A granted input that drops tvalid mid-packet keeps the grant; the arbiter waits indefinitely. There is no timeout.
- tvalid on non-granted inputs has no effect during XFER.

## Timing
- Reset (rst=0 at an edge):
  - m_outbuf_axis_tvalid=0, s_inbuf_axis_tready=0, m_grant_id=0.
  - rr_ptr=0, grant_q=0, FSM=ARB.
  - Any in-flight packet is abandoned; no partial-packet recovery.
- Latency: input valid at cycle N in ARB gives ready at N+1 and output valid at N+2.
- Steady state: one beat per cycle while the downstream holds ready high.
- Packet-to-packet gap: one ARB cycle. Back-to-back packets yield one input-side bubble; the output may show one idle cycle.
- Backpressure: with m_outbuf_axis_tready=0 and a full output register, the granted tready is 0 in that same cycle (combinational from out_ready). No beat is lost or duplicated.
- Output register contents are held stable while tvalid=1 and tready=0.
- Inputs that become valid while the FSM is in ARB are sampled the same cycle. The lowest index at or after rr_ptr wins.

## Configuration
- EVENT_ARB_STATS_EN defined:
  - Adds output m_pkt_count, NUM_IN*32 bits: one wrapping 32-bit counter per input.
  - A counter increments on acceptance of a tlast beat from that input.
  - Counters clear on reset.
- Not defined: the port and counters are absent. All other behaviour is identical.

## Structure
- Shared package event_arb_pkg:
  - typedef arb_state_t {ARB, XFER}
  - function rr_next(ptr, NUM_IN) for wrap-increment
  - default width constants 512/64
- Natural sub-module: rr_pick, a combinational circular priority encoder.
  - Inputs: req vector, start pointer.
  - Outputs: index, found flag.
- The FSM, output register and counters stay in the top module.

## Test plan
- Reset then idle: all tvalid=0 for 20 cycles -> m_outbuf_axis_tvalid=0, all tready=0, m_grant_id=0.
- Fairness: NUM_IN=4, inputs 0..3 each continuously offering 2-beat packets -> output grant order 0,1,2,3,0,1,…. No tlast is ever split across IDs.
- Non-interleave: input 2 sends a 5-beat packet while input 0 asserts tvalid at beat 2 -> all 5 beats carry m_grant_id=2 before any beat from 0.
- Backpressure: m_outbuf_axis_tready toggled 1,0,0,1 during a 4-beat packet from input 1 -> beats emerge in order, tdata stable while stalled, exactly 4 output handshakes.
- Reset mid-packet: rst=0 at beat 2 of 4 from input 3 -> next cycle tvalid=0, rr_ptr=0. After release, a pending input 0 is granted first.
- With EVENT_ARB_STATS_EN: 3 packets from input 1 and 1 from input 2 -> m_pkt_count slices read 0,3,1,0.
